// File: rtl/n64_vinfo_ctrl.sv
// n64_vinfo_ctrl: builds the 6-bit deblur parameter word for the N64 video
// pipeline. It tracks the R/G/B data phase, counts lines per field for the
// NTSC/PAL decision, detects 480i from field-parity alternation, and only
// applies frame-level settings at field boundaries through a lock FSM.
module n64_vinfo_ctrl #(
   parameter int color_width = 7,
   parameter int PAL_LINE_TH = 288,
   parameter int MIN_LINES   = 200,
   parameter int MAX_LINES   = 350
) (
   input  logic                   VCLK,
   input  logic                   nRST,
   input  logic                   nDSYNC,
   input  logic [color_width-1:0] D_i,
   input  logic                   nForceDeBlur_i,
   input  logic                   nDeBlurMan_i,
   output logic [5:0]             deblurparams_o,
   output logic                   vinfo_valid
);

   localparam logic [9:0] LP_PAL_TH = 10'(PAL_LINE_TH);
   localparam logic [9:0] LP_MIN    = 10'(MIN_LINES);
   localparam logic [9:0] LP_MAX    = 10'(MAX_LINES);
   localparam logic [9:0] LP_SAT    = 10'h3FF;

   typedef enum logic [1:0] {
      WAIT_VS = 2'd0,
      MEAS    = 2'd1,
      LOCK    = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_state_next;

   logic [1:0] r_data_cnt;
   logic [3:0] r_sync_prev;
   logic [9:0] r_line_cnt;
   logic       r_par_prev;
   logic [1:0] r_il_cnt;
   logic       r_il_zero_prev;
   logic       r_cand;
   logic       r_vmode;
   logic       r_480i;
   logic       r_nforce;
   logic       r_nman;
   logic       r_valid;
   logic [1:0] r_force_sync;
   logic [1:0] r_man_sync;

   logic       w_vs_fall;
   logic       w_hs_rise;
   logic       w_plausible;
   logic [9:0] w_line_inc;
   logic       w_sat;
   logic [1:0] w_il_next;
   logic       w_cand_next;
   logic       w_update_mode;
   logic       w_valid_next;
   logic       w_unused;

   // Edges of the sync lines only exist on sync words; data words are ignored.
   assign w_vs_fall   = !nDSYNC & r_sync_prev[3] & !D_i[3];
   assign w_hs_rise   = !nDSYNC & !r_sync_prev[1] & D_i[1];
   assign w_plausible = (r_line_cnt >= LP_MIN) && (r_line_cnt <= LP_MAX);
   assign w_line_inc  = (r_line_cnt == LP_SAT) ? r_line_cnt : r_line_cnt + 10'd1;

   // Saturation is flagged on the very word that reaches 1023 so lock drops without delay.
   assign w_sat = w_hs_rise & !w_vs_fall & (w_line_inc == LP_SAT);

   // Upper bus bits, nCLAMP and nCSYNC carry nothing this block needs.
   assign w_unused = ^{1'b0, D_i[color_width-1:4], r_sync_prev[2], r_sync_prev[0]};

   // Interlace tracking: count consecutive parity flips, candidate hysteresis.
   always_comb begin
      w_il_next   = 2'd0;
      w_cand_next = r_cand;
      if (r_line_cnt[0] != r_par_prev)
         w_il_next = (r_il_cnt == 2'd3) ? 2'd3 : r_il_cnt + 2'd1;
      if (w_il_next == 2'd2)
         w_cand_next = 1'b1;
      else if ((w_il_next == 2'd0) && r_il_zero_prev)
         w_cand_next = 1'b0;
   end

   // Lock FSM state register.
   always_ff @(posedge VCLK) begin
      if (!nRST) r_state <= WAIT_VS;
      else       r_state <= w_state_next;
   end

   // Lock FSM next-state decode.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         WAIT_VS: if (w_vs_fall) w_state_next = MEAS;
         MEAS:    if (w_vs_fall && w_plausible) w_state_next = LOCK;
         LOCK: begin
            if (w_vs_fall && !w_plausible) w_state_next = MEAS;
            else if (w_sat)                w_state_next = MEAS;
         end
         default: w_state_next = WAIT_VS;
      endcase
   end

   // Lock FSM outputs: when to load video mode and what vinfo_valid becomes.
   always_comb begin
      w_update_mode = 1'b0;
      w_valid_next  = r_valid;
      case (r_state)
         MEAS: begin
            if (w_vs_fall && w_plausible) begin
               w_update_mode = 1'b1;
               w_valid_next  = 1'b1;
            end
         end
         LOCK: begin
            if (w_vs_fall && w_plausible) w_update_mode = 1'b1;
            if ((w_vs_fall && !w_plausible) || w_sat) w_valid_next = 1'b0;
         end
         default: ;
      endcase
   end

   // Data phase, sync history, line counting and switch synchronizers.
   always_ff @(posedge VCLK) begin
      if (!nRST) begin
         r_data_cnt   <= 2'b00;
         r_sync_prev  <= 4'hF;
         r_line_cnt   <= 10'd0;
         r_force_sync <= 2'b11;
         r_man_sync   <= 2'b11;
      end else begin
         r_data_cnt   <= nDSYNC ? r_data_cnt + 2'd1 : 2'b01;
         r_force_sync <= {r_force_sync[0], nForceDeBlur_i};
         r_man_sync   <= {r_man_sync[0], nDeBlurMan_i};
         if (!nDSYNC) r_sync_prev <= D_i[3:0];
         if (w_vs_fall)      r_line_cnt <= 10'd0;
         else if (w_hs_rise) r_line_cnt <= w_line_inc;
      end
   end

   // Field-boundary updates: parity history, 480i candidate and output settings.
   always_ff @(posedge VCLK) begin
      if (!nRST) begin
         r_par_prev     <= 1'b0;
         r_il_cnt       <= 2'd0;
         r_il_zero_prev <= 1'b0;
         r_cand         <= 1'b0;
         r_vmode        <= 1'b0;
         r_480i         <= 1'b0;
         r_nforce       <= 1'b1;
         r_nman         <= 1'b1;
         r_valid        <= 1'b0;
      end else begin
         r_valid <= w_valid_next;
         if (w_vs_fall) begin
            r_par_prev     <= r_line_cnt[0];
            r_il_cnt       <= w_il_next;
            r_il_zero_prev <= (w_il_next == 2'd0);
            r_cand         <= w_cand_next;
            r_nforce       <= r_force_sync[1];
            r_nman         <= r_man_sync[1];
         end
         if (w_update_mode) begin
            r_vmode <= (r_line_cnt > LP_PAL_TH);
            r_480i  <= w_cand_next;
         end
      end
   end

   assign deblurparams_o = {r_data_cnt, r_480i, r_vmode, r_nforce, r_nman};
   assign vinfo_valid    = r_valid;

endmodule

// File: tb/tb_n64_vinfo_ctrl.sv
// tb_n64_vinfo_ctrl: directed bench for n64_vinfo_ctrl. Expected
// {vinfo_valid, deblurparams_o} words are queued when a step is driven and
// popped for comparison just after the clock edge that consumes it.
module tb_n64_vinfo_ctrl;

   logic       VCLK = 1'b0;
   logic       nRST = 1'b0;
   logic       nDSYNC = 1'b1;
   logic [6:0] D_i = 7'h00;
   logic       nForceDeBlur_i = 1'b1;
   logic       nDeBlurMan_i = 1'b1;
   logic [5:0] deblurparams_o;
   logic       vinfo_valid;

   int         vectorCount = 0;
   int         missCount = 0;
   logic [6:0] expQ[$];
   string      tagQ[$];

   // Sync word nibbles {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
   localparam logic [3:0] SW_IDLE  = 4'hF;
   localparam logic [3:0] SW_HLOW  = 4'hD;
   localparam logic [3:0] SW_VSYNC = 4'h7;

   // 100 MHz-style free-running video clock
   always #5 VCLK = ~VCLK;

   n64_vinfo_ctrl dut (
      .VCLK           (VCLK),
      .nRST           (nRST),
      .nDSYNC         (nDSYNC),
      .D_i            (D_i),
      .nForceDeBlur_i (nForceDeBlur_i),
      .nDeBlurMan_i   (nDeBlurMan_i),
      .deblurparams_o (deblurparams_o),
      .vinfo_valid    (vinfo_valid)
   );

   // Expected word right after a sync word: data phase is 01
   function automatic logic [6:0] expWord(input logic valid, input logic i480,
                                          input logic vmode, input logic nF,
                                          input logic nM);
      return {valid, 2'b01, i480, vmode, nF, nM};
   endfunction

   // Drive one bus word, let the DUT take it, then settle past the edge
   task automatic applyStimulus(input logic nds, input logic [3:0] bits);
      nDSYNC = nds;
      D_i    = nds ? 7'h55 : {3'b000, bits};
      @(posedge VCLK);
      #1;
   endtask

   task automatic expectOut(input string tag, input logic [6:0] value);
      expQ.push_back(value);
      tagQ.push_back(tag);
   endtask

   task automatic checkOutput();
      logic [6:0] exp;
      logic [6:0] obs;
      string      tag;
      exp = expQ.pop_front();
      tag = tagQ.pop_front();
      obs = {vinfo_valid, deblurparams_o};
      vectorCount++;
      assert (obs === exp) else begin
         missCount++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic runLines(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, SW_HLOW);
         applyStimulus(1'b0, SW_IDLE);
      end
   endtask

   task automatic vsyncCheck(input string tag, input logic [6:0] value);
      expectOut(tag, value);
      applyStimulus(1'b0, SW_VSYNC);
      checkOutput();
   endtask

   initial begin
      $display("[TB] start");
      applyStimulus(1'b1, 4'h0);
      applyStimulus(1'b1, 4'h0);
      nRST = 1'b1;

      // Get into lock first so the mid-frame reset has something to clear
      vsyncCheck("pre_vs1", expWord(0, 0, 0, 1, 1));
      runLines(263);
      vsyncCheck("pre_lock", expWord(1, 0, 0, 1, 1));
      runLines(50);

      // Reset asserted while a vsync word is on the bus: reset must win
      nRST = 1'b0;
      applyStimulus(1'b0, SW_VSYNC);
      expectOut("reset", 7'b0_000011);
      applyStimulus(1'b0, SW_VSYNC);
      checkOutput();
      nRST = 1'b1;

      // Data phase sequence after a sync word, including the silent wrap
      expectOut("dcnt_sync", 7'b0_010011); applyStimulus(1'b0, SW_IDLE); checkOutput();
      expectOut("dcnt_d1",   7'b0_100011); applyStimulus(1'b1, 4'h0);    checkOutput();
      expectOut("dcnt_d2",   7'b0_110011); applyStimulus(1'b1, 4'h0);    checkOutput();
      expectOut("dcnt_wrap", 7'b0_000011); applyStimulus(1'b1, 4'h0);    checkOutput();

      // NTSC 240p: valid only after the second vsync
      vsyncCheck("vs1_meas", expWord(0, 0, 0, 1, 1));
      runLines(263);
      expectOut("prelock_invalid", expWord(0, 0, 0, 1, 1));
      checkOutput();
      vsyncCheck("vs2_lock", expWord(1, 0, 0, 1, 1));
      runLines(263);
      vsyncCheck("vs3_240p", expWord(1, 0, 0, 1, 1));

      // PAL field
      runLines(313);
      vsyncCheck("vs4_pal", expWord(1, 0, 1, 1, 1));

      // 480i: alternating parity sets the flag on the second flip
      runLines(262);
      vsyncCheck("vs5_il1", expWord(1, 0, 0, 1, 1));
      runLines(263);
      vsyncCheck("vs6_480i", expWord(1, 1, 0, 1, 1));
      runLines(262);
      vsyncCheck("vs7_480i", expWord(1, 1, 0, 1, 1));
      runLines(263);
      vsyncCheck("vs8_480i", expWord(1, 1, 0, 1, 1));
      runLines(263);
      vsyncCheck("vs9_hold", expWord(1, 1, 0, 1, 1));
      runLines(263);
      vsyncCheck("vs10_clr", expWord(1, 0, 0, 1, 1));

      // Implausible field drops lock but holds vmode
      runLines(313);
      vsyncCheck("vs11_pal", expWord(1, 0, 1, 1, 1));
      runLines(121);
      vsyncCheck("vs12_implaus", expWord(0, 0, 1, 1, 1));
      runLines(263);
      vsyncCheck("vs13_relock", expWord(1, 0, 0, 1, 1));

      // Switch changes only land at field boundaries, after the synchronizer
      runLines(100);
      nForceDeBlur_i = 1'b0;
      runLines(162);
      expectOut("sw_midfield", expWord(1, 0, 0, 1, 1));
      checkOutput();
      applyStimulus(1'b0, SW_HLOW);
      nDeBlurMan_i = 1'b0;
      applyStimulus(1'b0, SW_IDLE);
      vsyncCheck("vs14_force", expWord(1, 0, 0, 0, 1));
      runLines(263);
      vsyncCheck("vs15_man", expWord(1, 0, 0, 0, 0));

      // Lost vsync: lock drops on the line that saturates the counter
      runLines(1022);
      expectOut("sat_minus1", expWord(1, 0, 0, 0, 0));
      checkOutput();
      applyStimulus(1'b0, SW_HLOW);
      expectOut("sat_drop", expWord(0, 0, 0, 0, 0));
      applyStimulus(1'b0, SW_IDLE);
      checkOutput();
      vsyncCheck("vsA_1023", expWord(0, 0, 0, 0, 0));

      // nHSYNC rise inside the vsync word is not counted: 350 stays plausible
      runLines(262);
      applyStimulus(1'b0, SW_HLOW);
      vsyncCheck("vsB_coinc", expWord(1, 0, 0, 0, 0));
      runLines(350);
      vsyncCheck("vsC_max350", expWord(1, 0, 1, 0, 0));
      runLines(200);
      vsyncCheck("vsD_min200", expWord(1, 0, 0, 0, 0));
      runLines(199);
      vsyncCheck("vsE_199", expWord(0, 0, 0, 0, 0));

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
